// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter.
// Holds the operation encodings driven on the op port and the FSM
// state encoding used by iter_shifter.
package shift_pkg;

  // Shift mode, matches the 2-bit op port encoding
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift stage.
// Purely combinational: moves i_value by exactly one bit position
// according to i_op.
//   i_value : WIDTH-bit value to shift
//   i_op    : shift mode (SLL / SRL / SRA / ROR)
//   o_value : i_value shifted by one bit
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_value
);

  always_comb begin
    o_value = i_value;
    case (i_op)
      OP_SLL: o_value = {i_value[WIDTH-2:0], 1'b0};
      OP_SRL: o_value = {1'b0, i_value[WIDTH-1:1]};
      // Replicating the current MSB keeps the sign on every step
      OP_SRA: o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
      // Bit shifted out of the bottom wraps into the MSB
      OP_ROR: o_value = {i_value[0], i_value[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Iterative (one bit per cycle) shifter.
// An operation is accepted when start and ready are high at a rising
// edge. The operand is then shifted one bit per cycle for shamt cycles,
// the result is registered on B and done pulses for one cycle.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   start : request, accepted only while ready is high
//   op    : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   A     : operand, sampled on accept
//   shamt : shift amount, sampled on accept
//   flush : cancels an operation in progress (no done, B unchanged)
//   ready : high while idle
//   done  : one-cycle pulse when B holds a new result
//   B     : result, held until the next done
module iter_shifter
  import shift_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   B
);

  state_e             r_state;
  state_e             w_next_state;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_B;
  logic [SHAMT_W-1:0] r_cnt;
  op_e                r_op;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_accept;
  logic               w_cnt_zero;

  // flush takes priority over start, so a simultaneous request is dropped
  assign w_accept   = start && (r_state == ST_IDLE) && !flush;
  assign w_cnt_zero = (r_cnt == '0);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_value (r_work),
    .i_op    (r_op),
    .o_value (w_shifted)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (flush)           w_next_state = ST_IDLE;
        else if (w_cnt_zero) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready = (r_state == ST_IDLE);
    done  = (r_state == ST_DONE);
  end

  // Datapath: operand capture, per-cycle shift and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_op   <= OP_SLL;
      r_B    <= '0;
    end else if (w_accept) begin
      r_work <= A;
      r_cnt  <= shamt;
      r_op   <= op_e'(op);
    end else if ((r_state == ST_SHIFT) && !flush) begin
      if (!w_cnt_zero) begin
        r_work <= w_shifted;
        r_cnt  <= r_cnt - SHAMT_W'(1);
      end else begin
        // Count exhausted: publish the result on the way to DONE
        r_B <= r_work;
      end
    end
  end

  assign B = r_B;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: directed corner cases plus
// randomized operations compared against a plain-arithmetic model.
module tb_iter_shifter;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  A;
  logic [4:0]    shamt;
  logic          flush;
  logic          ready;
  logic          done;
  logic [W-1:0]  B;

  int checks = 0;
  int errors = 0;

  iter_shifter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .shamt (shamt),
    .flush (flush),
    .ready (ready),
    .done  (done),
    .B     (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole shift in one arithmetic step
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] a, logic [1:0] o, int n);
    logic signed [W-1:0] sa;
    sa = a;
    case (o)
      2'd0:    return a << n;
      2'd1:    return a >> n;
      2'd2:    return sa >>> n;
      default: return (n == 0) ? a : ((a >> n) | (a << (W - n)));
    endcase
  endfunction

  // Issues one operation, scrambles inputs after accept, optionally pulses
  // start at cycle mid_start, and waits (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [1:0] o, input int n,
                        input int mid_start,
                        output logic [W-1:0] b, output int lat, output bit to,
                        output bit rdy_hi, output logic done_after,
                        output logic ready_after);
    start = 1'b1; A = a; op = o; shamt = n[4:0];
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; op = 2'($urandom); shamt = 5'($urandom);
    lat = 0; to = 1'b0; rdy_hi = 1'b0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        start = 1'b0;
        break;
      end
      if (ready) rdy_hi = 1'b1;
      start = (lat == mid_start);
      if (lat > W + 8) begin
        start = 1'b0;
        to = 1'b1;
        break;
      end
    end
    b = B;
    @(posedge clk); #1;
    done_after  = done;
    ready_after = ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; A = '0; shamt = '0;
    #2;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++;
    if (B !== '0) begin errors++; $display("FAIL reset_B got %h exp 0", B); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] b; int lat; bit to, rh; logic da, ra;
    // SRA sign fill, also the first accept right after reset release
    run_op(32'h8000_0000, 2'd2, 4, -1, b, lat, to, rh, da, ra);
    checks++;
    if (b !== 32'hF800_0000) begin errors++; $display("FAIL sra_B got %h exp f8000000", b); end
    checks++;
    if (lat != 5 || to) begin errors++; $display("FAIL sra_latency got %0d exp 5", lat); end
    checks++;
    if (rh) begin errors++; $display("FAIL sra_ready_low got high exp low"); end
    checks++;
    if (da !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL sra_done_pulse got done=%b ready=%b exp 0 1", da, ra); end

    run_op(32'h8000_0000, 2'd1, 4, -1, b, lat, to, rh, da, ra);
    checks++;
    if (b !== 32'h0800_0000) begin errors++; $display("FAIL srl_B got %h exp 08000000", b); end

    run_op(32'h0000_0001, 2'd3, 1, -1, b, lat, to, rh, da, ra);
    checks++;
    if (b !== 32'h8000_0000) begin errors++; $display("FAIL ror_B got %h exp 80000000", b); end
    checks++;
    if (lat != 2 || to) begin errors++; $display("FAIL ror_latency got %0d exp 2", lat); end

    run_op(32'h1234_5678, 2'd0, 0, -1, b, lat, to, rh, da, ra);
    checks++;
    if (b !== 32'h1234_5678) begin errors++; $display("FAIL sll0_B got %h exp 12345678", b); end
    checks++;
    if (lat != 1 || to) begin errors++; $display("FAIL sll0_latency got %0d exp 1", lat); end

    // Full-width shift with a start pulse mid-operation that must be ignored
    run_op(32'h0000_0001, 2'd0, 31, 10, b, lat, to, rh, da, ra);
    checks++;
    if (b !== 32'h8000_0000) begin errors++; $display("FAIL sll31_B got %h exp 80000000", b); end
    checks++;
    if (lat != 32 || to) begin errors++; $display("FAIL sll31_latency got %0d exp 32", lat); end
    checks++;
    if (ra !== 1'b1 || rh) begin errors++; $display("FAIL sll31_no_queue got ready_after=%b ready_mid=%b exp 1 0", ra, rh); end
  endtask

  task automatic test_flush();
    logic [W-1:0] b, prev; int lat; bit to, rh, seen; logic da, ra;
    run_op(32'hA5A5_0000, 2'd1, 3, -1, prev, lat, to, rh, da, ra);
    // Accept SLL 0xFF N=8, flush on the third SHIFT cycle
    start = 1'b1; A = 32'hFF; op = 2'd0; shamt = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL flush_idle got ready=%b done=%b exp 1 0", ready, done); end
    checks++;
    if (B !== prev) begin errors++; $display("FAIL flush_B_kept got %h exp %h", B, prev); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_no_done got done pulse exp none"); end

    run_op(32'hFF, 2'd0, 8, -1, b, lat, to, rh, da, ra);
    checks++;
    if (b !== 32'hFF00 || lat != 9) begin errors++; $display("FAIL flush_after_op got %h lat %0d exp 0000ff00 lat 9", b, lat); end

    // flush together with start in IDLE: nothing accepted
    start = 1'b1; flush = 1'b1; A = 32'h1; op = 2'd0; shamt = 5'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL flush_start_idle got ready=%b exp 1", ready); end

    // flush during DONE: result still delivered
    start = 1'b1; A = 32'h0000_00F0; op = 2'd1; shamt = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (!seen || B !== 32'h0000_000F || ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_done got seen=%b B=%h ready=%b exp 1 0000000f 1", seen, B, ready);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] b; int lat; bit to, rh, seen; logic da, ra;
    start = 1'b1; A = 32'hDEAD_BEEF; op = 2'd2; shamt = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || B !== '0) begin
      errors++; $display("FAIL async_reset got ready=%b done=%b B=%h exp 1 0 0", ready, done, B);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || B !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_discard got done/B activity exp none"); end
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    // First accept at the first rising edge after release
    run_op(32'h8000_0F00, 2'd2, 7, -1, b, lat, to, rh, da, ra);
    checks++;
    if (b !== ref_shift(32'h8000_0F00, 2'd2, 7) || lat != 8 || to) begin
      errors++; $display("FAIL first_accept got %h lat %0d exp %h lat 8", b, lat, ref_shift(32'h8000_0F00, 2'd2, 7));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] b, a, exp; logic [1:0] o; int n, lat, ms; bit to, rh; logic da, ra;
    for (int k = 0; k < 30; k++) begin
      a  = $urandom;
      o  = 2'($urandom);
      n  = $urandom_range(0, W - 1);
      ms = ($urandom_range(0, 1) == 1 && n > 2) ? $urandom_range(1, n - 1) : -1;
      exp = ref_shift(a, o, n);
      run_op(a, o, n, ms, b, lat, to, rh, da, ra);
      checks++;
      if (b !== exp || lat != n + 1 || to || rh || da !== 1'b0) begin
        errors++;
        $display("FAIL random op=%0d n=%0d a=%h got %h lat %0d exp %h lat %0d", o, n, a, b, lat, exp, n + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] b, a, exp; logic [1:0] o; int n, lat; bit to, rh; logic da, ra;
    time t0, t1;
    for (int k = 0; k < 8; k++) begin
      a = $urandom;
      o = 2'(k);
      n = $urandom_range(0, 12);
      exp = ref_shift(a, o, n);
      t0 = $time;
      run_op(a, o, n, -1, b, lat, to, rh, da, ra);
      t1 = $time;
      checks++;
      if (b !== exp || lat != n + 1 || ra !== 1'b1) begin
        errors++;
        $display("FAIL b2b op=%0d n=%0d got %h lat %0d ready=%b exp %h lat %0d ready=1", o, n, b, lat, ra, exp, n + 1);
      end
      checks++;
      if ((t1 - t0) != time'((n + 3) * 10)) begin
        errors++; $display("FAIL b2b_throughput got %0t exp %0d", t1 - t0, (n + 3) * 10);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
